// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  localparam logic [7:0] AES_POLY = 8'h1b;
  localparam int         NUM_COLS = 4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_seq_mx.sv
// Combinational MixColumns for a single 32-bit column; byte s0 is the MSB.
module mx
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] s0, s1, s2, s3;
  logic [7:0] x0, x1, x2, x3;

  always_comb begin
    s0 = col_in[31:24];
    s1 = col_in[23:16];
    s2 = col_in[15:8];
    s3 = col_in[7:0];
    x0 = xtime(s0);
    x1 = xtime(s1);
    x2 = xtime(s2);
    x3 = xtime(s3);
    // 3*s is xtime(s)^s
    col_out[31:24] = x0 ^ (x1 ^ s1) ^ s2 ^ s3;
    col_out[23:16] = s0 ^ x1 ^ (x2 ^ s2) ^ s3;
    col_out[15:8]  = s0 ^ s1 ^ x2 ^ (x3 ^ s3);
    col_out[7:0]   = (x0 ^ s0) ^ s1 ^ s2 ^ x3;
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns: one column per cycle through a shared mx unit, with final-round bypass.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  mc_state_e state_q, state_d;
  state_t    buf_q, buf_d;
  logic [1:0] col_q, col_d;

  col_t   mx_in, mx_out;
  state_t wb;

  mx u_mx (
    .col_in (mx_in),
    .col_out(mx_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      col_q   <= col_d;
    end
  end

  // Column select mux and write-back demux around the shared unit
  always_comb begin
    mx_in = '0;
    wb    = buf_q;
    case (col_q)
      2'd0: begin mx_in = buf_q[127:96]; wb[127:96] = mx_out; end
      2'd1: begin mx_in = buf_q[95:64];  wb[95:64]  = mx_out; end
      2'd2: begin mx_in = buf_q[63:32];  wb[63:32]  = mx_out; end
      default: begin mx_in = buf_q[31:0]; wb[31:0] = mx_out; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          buf_d   = in_data;
          col_d   = '0;
          state_d = in_skip ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        buf_d = wb;
        col_d = col_q + 2'd1;
        if (col_q == 2'(NUM_COLS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_data  = buf_q;
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: expectations queued at accept, checked at output.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_skip;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] COL_IN   = 128'hd4d4d4d5_2d26314c_00000000_80808080;
  localparam logic [127:0] COL_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_80808080;

  mix_columns_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_skip  (in_skip),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model_mc(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] b[4];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = s[127 - 32*c - 8*k -: 8];
      r[127 - 32*c      -: 8] = gmul(b[0], 2) ^ gmul(b[1], 3) ^ b[2] ^ b[3];
      r[127 - 32*c - 8  -: 8] = b[0] ^ gmul(b[1], 2) ^ gmul(b[2], 3) ^ b[3];
      r[127 - 32*c - 16 -: 8] = b[0] ^ b[1] ^ gmul(b[2], 2) ^ gmul(b[3], 3);
      r[127 - 32*c - 24 -: 8] = gmul(b[0], 3) ^ b[1] ^ b[2] ^ gmul(b[3], 2);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and wait (bounded) for the accept edge; leaves in_valid low afterwards.
  task automatic send(input logic [127:0] d, input logic skip, output logic ok);
    int n = 0;
    in_data  = d;
    in_skip  = skip;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
    in_skip  = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns cycles waited and the data seen.
  task automatic collect(output int lat, output logic [127:0] d);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    d = out_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_skip = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0) begin
      fails++;
      $display("FAIL reset: in_ready/out_valid/busy=%b out_data=%h, required 100 and 0",
               {in_ready, out_valid, busy}, out_data);
    end
  endtask

  task automatic test_fips();
    logic ok; int lat; logic [127:0] d, e;
    out_ready = 1'b1;
    send(FIPS_IN, 1'b0, ok);
    exp_q.push_back(FIPS_OUT);
    collect(lat, d);
    tests++;
    if (!ok || lat !== 4) begin
      fails++; $display("FAIL fips_latency: got %0d cycles (accepted=%b), required 4", lat, ok);
    end
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL fips_data: got %h, required %h", d, e); end
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL fips_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_per_column();
    logic ok; int lat; logic [127:0] d, e;
    out_ready = 1'b1;
    send(COL_IN, 1'b0, ok);
    exp_q.push_back(model_mc(COL_IN));
    collect(lat, d);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || d !== COL_OUT) begin
      fails++; $display("FAIL per_column: got %h, required %h", d, COL_OUT);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic ok; logic [127:0] v, e;
    v = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    send(v, 1'b1, ok);
    exp_q.push_back(v);
    e = exp_q.pop_front();
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== e) begin
      fails++;
      $display("FAIL bypass_out: out_valid=%b busy=%b data=%h, required 1 1 %h", out_valid, busy, out_data, e);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bypass_busy: busy=%b in_ready=%b after handshake, required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic ok; int lat; logic [127:0] a, b, d, e;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(a, 1'b0, ok);
    exp_q.push_back(model_mc(a));
    collect(lat, d);
    in_data = b; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d) begin
        fails++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b data=%h, required 1 0 %h",
                 i, out_valid, in_ready, out_data, d);
      end
    end
    e = exp_q.pop_front();
    tests++;
    if (out_data !== e) begin fails++; $display("FAIL bp_data: got %h, required %h", out_data, e); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model_mc(b));
    out_ready = 1'b1;
    collect(lat, d);
    e = exp_q.pop_front();
    tests++;
    if (lat !== 4 || d !== e) begin
      fails++; $display("FAIL bp_next: lat=%0d data=%h, required 4 %h", lat, d, e);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic ok; int lat; logic [127:0] d;
    out_ready = 1'b1;
    send(FIPS_IN, 1'b0, ok);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0) begin
      fails++;
      $display("FAIL mid_run_reset: in_ready/out_valid/busy=%b data=%h, required 100 and 0",
               {in_ready, out_valid, busy}, out_data);
    end
    send(FIPS_IN, 1'b0, ok);
    exp_q.push_back(FIPS_OUT);
    collect(lat, d);
    tests++;
    if (lat !== 4 || d !== exp_q.pop_front()) begin
      fails++; $display("FAIL post_reset_fips: lat=%0d data=%h, required 4 %h", lat, d, FIPS_OUT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] v[3];
    logic [127:0] got, e;
    int n_in = 0, n_out = 0, last = 0;
    logic acc, hs;
    v[0] = FIPS_IN;
    v[1] = COL_IN;
    v[2] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; in_skip = 1'b0; in_data = v[0]; in_valid = 1'b1;
    for (int c = 0; c < 60 && n_out < 3; c++) begin
      acc = in_ready && (n_in < 3);
      hs  = out_valid;
      got = out_data;
      tick();
      if (acc) begin
        exp_q.push_back(model_mc(v[n_in]));
        n_in++;
        if (n_in < 3) in_data = v[n_in]; else in_valid = 1'b0;
      end
      if (hs) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        tests++;
        if (got !== e) begin fails++; $display("FAIL b2b_data[%0d]: got %h, required %h", n_out, got, e); end
        if (n_out > 0) begin
          tests++;
          if (c - last !== 6) begin fails++; $display("FAIL b2b_period[%0d]: got %0d, required 6", n_out, c - last); end
        end
        last = c;
        n_out++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (n_out !== 3 || exp_q.size() !== 0) begin
      fails++; $display("FAIL b2b_count: outputs=%0d leftover=%0d, required 3 0", n_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_per_column();
    test_bypass();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
